// File: rtl/reg_bus_pkg.sv
// Shared types for the register-bus master: FSM state and queued request.
// Package-level widths are the defaults for the standard 8/16 register map.
package reg_bus_pkg;

  localparam int REG_ADDR_W = 8;
  localparam int REG_DATA_W = 16;

  typedef enum logic {
    ISSUE   = 1'b0,
    RD_WAIT = 1'b1
  } bus_state_e;

  typedef struct packed {
    logic                  wr;
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] wdata;
  } reg_req_t;

endpackage

// File: rtl/reg_bus_fifo.sv
// Request FIFO with first-word-fall-through head.
// Ports: push/din in, pop in, head out, empty out, count out.
module reg_bus_fifo
  import reg_bus_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = reg_req_t
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push,
  input  T                           din,
  input  logic                       pop,
  output T                           head,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  T                mem_q [DEPTH];
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            full;
  logic            do_push, do_pop;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
  assign head  = mem_q[rptr_q];

  // DEPTH is a power of two, so pointers wrap naturally.
  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
    wptr_d  = wptr_q + PW'(do_push);
    rptr_d  = rptr_q + PW'(do_pop);
    cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din;
  end

endmodule

// File: rtl/reg_bus_master.sv
// Register-bus master: queues requests, issues them in order, returns reads.
// Ports: req_* in (valid/ready), rsp_* out (valid/ready), bus_* to slave, busy.
module reg_bus_master
  import reg_bus_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  bus_sel,
  output logic                  bus_wr,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  input  logic                  bus_ready,
  output logic                  busy
);

  localparam int CW = $clog2(FIFO_DEPTH+1);

  typedef struct packed {
    logic                  wr;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  req_t            push_req;
  req_t            head;
  logic            fifo_empty;
  logic            fifo_pop;
  logic [CW-1:0]   fifo_count;

  bus_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [ADDR_WIDTH-1:0] rsp_addr_q, rsp_addr_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

  assign push_req  = '{wr: req_wr, addr: req_addr, wdata: req_wdata};
  assign req_ready = (fifo_count != CW'(FIFO_DEPTH));

  reg_bus_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (req_t)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (req_valid && req_ready),
    .din   (push_req),
    .pop   (fifo_pop),
    .head  (head),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    bus_sel     = 1'b0;
    bus_wr      = 1'b0;
    bus_addr    = '0;
    bus_wdata   = '0;
    fifo_pop    = 1'b0;
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_addr_d  = rsp_addr_q;
    rsp_rdata_d = rsp_rdata_q;

    if (rsp_valid_q && rsp_ready) rsp_valid_d = 1'b0;

    unique case (state_q)
      ISSUE: begin
        // A read waits for a free response slot; writes never do.
        bus_sel = !fifo_empty && (head.wr || !rsp_valid_q);
        if (bus_sel) begin
          bus_wr    = head.wr;
          bus_addr  = head.addr;
          bus_wdata = head.wdata;
        end
        if (bus_sel && bus_ready) begin
          fifo_pop = 1'b1;
          if (!head.wr) begin
            rd_addr_d = head.addr;
            state_d   = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        // Keep sel high so the slave re-raises ready next cycle.
        bus_sel     = 1'b1;
        bus_addr    = rd_addr_q;
        rsp_valid_d = 1'b1;
        rsp_addr_d  = rd_addr_q;
        rsp_rdata_d = bus_rdata;
        state_d     = ISSUE;
      end
      default: state_d = ISSUE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= ISSUE;
      rd_addr_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_addr_q  <= '0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_addr  = rsp_addr_q;
  assign rsp_rdata = rsp_rdata_q;
  assign busy      = !fifo_empty || (state_q != ISSUE);

endmodule

// File: tb/tb_reg_bus_master.sv
// Testbench for reg_bus_master with a behavioural register slave,
// directed corner sequences, a vector table and a random scoreboard run.
module tb_reg_bus_master;

  logic        clk;
  logic        rstn;
  logic        req_valid, req_ready, req_wr;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid, rsp_ready;
  logic [7:0]  rsp_addr;
  logic [15:0] rsp_rdata;
  logic        bus_sel, bus_wr;
  logic [7:0]  bus_addr;
  logic [15:0] bus_wdata, bus_rdata;
  logic        bus_ready;
  logic        busy;

  int n_cmp = 0;
  int n_fail = 0;

  reg_bus_master #(
    .ADDR_WIDTH (8),
    .DATA_WIDTH (16),
    .FIFO_DEPTH (4)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_addr  (rsp_addr),
    .rsp_rdata (rsp_rdata),
    .bus_sel   (bus_sel),
    .bus_wr    (bus_wr),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ready (bus_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Behavioural register slave: regs reset to 0x1234, one wait cycle on reads.
  logic [15:0] smem [256];
  logic        s_wait;
  logic [7:0]  s_addr;
  logic        stall;

  assign bus_ready = !s_wait && !stall;
  assign bus_rdata = s_wait ? smem[s_addr] : 16'h0;

  always @(posedge clk) begin
    if (!rstn) begin
      s_wait <= 1'b0;
      for (int i = 0; i < 256; i++) smem[i] <= 16'h1234;
    end else if (s_wait) begin
      if (bus_sel) s_wait <= 1'b0;
    end else if (bus_sel && bus_ready) begin
      if (bus_wr) smem[bus_addr] <= bus_wdata;
      else begin
        s_wait <= 1'b1;
        s_addr <= bus_addr;
      end
    end
  end

  always @(negedge clk) begin
    if (rstn && s_wait) begin
      check("wait_sel", 32'(bus_sel), 1);
      check("wait_wr", 32'(bus_wr), 0);
      check("wait_wdata", 32'(bus_wdata), 0);
      check("wait_addr", 32'(bus_addr), 32'(s_addr));
    end
  end

  // Reference model: an in-order memory image and expected-traffic queues.
  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [15:0] wdata;
  } bus_t;
  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
  } rsp_t;

  logic [15:0] mdl [256];
  bus_t        bus_q [$];
  rsp_t        exp_q [$];
  logic        mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus_sel && bus_ready) begin
        if (bus_q.size() == 0) check("bus_unexpected", 1, 0);
        else begin
          bus_t b;
          b = bus_q.pop_front();
          check("rnd_bus_wr", 32'(bus_wr), 32'(b.wr));
          check("rnd_bus_addr", 32'(bus_addr), 32'(b.addr));
          if (b.wr) check("rnd_bus_wdata", 32'(bus_wdata), 32'(b.wdata));
        end
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) check("rsp_unexpected", 1, 0);
        else begin
          rsp_t r;
          r = exp_q.pop_front();
          check("rnd_rsp_addr", 32'(rsp_addr), 32'(r.addr));
          check("rnd_rsp_data", 32'(rsp_rdata), 32'(r.data));
        end
      end
      if (req_valid && req_ready) begin
        bus_q.push_back('{req_wr, req_addr, req_wdata});
        if (req_wr) mdl[req_addr] = req_wdata;
        else exp_q.push_back('{req_addr, mdl[req_addr]});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rstn = 1'b0;
    step();
    step();
    rstn = 1'b1;
  endtask

  // Presents one request and returns just after the cycle it is taken.
  task automatic push(input logic wr, input logic [7:0] a,
                      input logic [15:0] d);
    bit ok;
    ok = 0;
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = a;
    req_wdata = d;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      if (req_ready) ok = 1;
      step();
    end
    if (!ok) check("push_timeout", 0, 1);
    req_valid = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int n, cyc, nxt;
    bit hs, done;

    vecs[0]  = '{1'b1, 8'h60, 16'hBEEF, 16'h0};
    vecs[1]  = '{1'b0, 8'h60, 16'h0,    16'hBEEF};
    vecs[2]  = '{1'b0, 8'h61, 16'h0,    16'h1234};
    vecs[3]  = '{1'b1, 8'h61, 16'h0001, 16'h0};
    vecs[4]  = '{1'b0, 8'h61, 16'h0,    16'h0001};
    vecs[5]  = '{1'b1, 8'h60, 16'hFFFF, 16'h0};
    vecs[6]  = '{1'b0, 8'h60, 16'h0,    16'hFFFF};
    vecs[7]  = '{1'b0, 8'hFF, 16'h0,    16'h1234};
    vecs[8]  = '{1'b1, 8'h00, 16'h0000, 16'h0};
    vecs[9]  = '{1'b0, 8'h00, 16'h0,    16'h0000};
    vecs[10] = '{1'b1, 8'hFF, 16'hA5A5, 16'h0};
    vecs[11] = '{1'b0, 8'hFF, 16'h0,    16'hA5A5};

    rstn = 1'b0;
    req_valid = 1'b0;
    req_wr = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;
    stall = 1'b0;

    // Reset values, then a single write.
    reset_dut();
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 1);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_addr", 32'(rsp_addr), 0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 0);
    check("rst_bus_sel", 32'(bus_sel), 0);
    check("rst_bus_wr", 32'(bus_wr), 0);
    check("rst_busy", 32'(busy), 0);
    step();
    push(1'b1, 8'h10, 16'hBEEF);
    @(negedge clk);
    check("w1_sel", 32'(bus_sel), 1);
    check("w1_wr", 32'(bus_wr), 1);
    check("w1_addr", 32'(bus_addr), 32'h10);
    check("w1_wdata", 32'(bus_wdata), 32'hBEEF);
    step();
    @(negedge clk);
    check("w1_done_sel", 32'(bus_sel), 0);
    check("w1_done_busy", 32'(busy), 0);
    check("w1_no_rsp", 32'(rsp_valid), 0);
    check("idle_wdata", 32'(bus_wdata), 0);
    step();

    // Write then read-back; read latency of two cycles.
    rsp_ready = 1'b1;
    push(1'b1, 8'h10, 16'hBEEF);
    push(1'b0, 8'h10, 16'h0);
    @(negedge clk);
    check("rd_acc_sel", 32'(bus_sel), 1);
    check("rd_acc_wr", 32'(bus_wr), 0);
    check("rd_acc_addr", 32'(bus_addr), 32'h10);
    step();
    @(negedge clk);
    check("rd_wait_sel", 32'(bus_sel), 1);
    check("rd_wait_rsp", 32'(rsp_valid), 0);
    step();
    @(negedge clk);
    check("rd_rsp_valid", 32'(rsp_valid), 1);
    check("rd_rsp_addr", 32'(rsp_addr), 32'h10);
    check("rd_rsp_data", 32'(rsp_rdata), 32'hBEEF);
    check("rd_after_sel", 32'(bus_sel), 0);
    step();
    @(negedge clk);
    check("rd_consumed", 32'(rsp_valid), 0);
    step();

    // Second read blocked while the first response is held.
    rsp_ready = 1'b0;
    push(1'b0, 8'h01, 16'h0);
    push(1'b0, 8'h02, 16'h0);
    step();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("blk_sel", 32'(bus_sel), 0);
      check("blk_rsp_valid", 32'(rsp_valid), 1);
      step();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("blk_rsp1_addr", 32'(rsp_addr), 32'h01);
    check("blk_rsp1_data", 32'(rsp_rdata), 32'h1234);
    step();
    rsp_ready = 1'b0;
    @(negedge clk);
    check("blk_rd2_sel", 32'(bus_sel), 1);
    check("blk_rd2_addr", 32'(bus_addr), 32'h02);
    step();
    step();
    @(negedge clk);
    check("blk_rsp2_valid", 32'(rsp_valid), 1);
    check("blk_rsp2_addr", 32'(rsp_addr), 32'h02);
    check("blk_rsp2_data", 32'(rsp_rdata), 32'h1234);
    rsp_ready = 1'b1;
    step();

    // Fill with the slave stalled, then drain in order.
    stall = 1'b1;
    for (int i = 0; i < 4; i++) push(1'b1, 8'(8'h20 + i), 16'(16'hA000 + i));
    @(negedge clk);
    check("full_ready", 32'(req_ready), 0);
    check("full_busy", 32'(busy), 1);
    req_valid = 1'b1;
    req_wr = 1'b1;
    req_addr = 8'h24;
    req_wdata = 16'hA004;
    step();
    @(negedge clk);
    check("full_hold_ready", 32'(req_ready), 0);
    step();
    stall = 1'b0;
    n = 0;
    cyc = 0;
    while (n < 5 && cyc < 12) begin
      @(negedge clk);
      if (bus_sel && bus_ready) begin
        check("drain_addr", 32'(bus_addr), 32'h20 + n);
        check("drain_wdata", 32'(bus_wdata), 32'hA000 + n);
        n++;
      end
      hs = req_valid && req_ready;
      step();
      cyc++;
      if (hs) req_valid = 1'b0;
    end
    check("drain_count", n, 5);
    check("drain_cycles", cyc, 5);

    // Continuous streaming from full across three pointer laps.
    stall = 1'b1;
    for (int i = 0; i < 4; i++) push(1'b1, 8'(8'h40 + i), 16'(16'hB000 + i));
    nxt = 4;
    req_valid = 1'b1;
    req_wr = 1'b1;
    req_addr = 8'h44;
    req_wdata = 16'hB004;
    stall = 1'b0;
    n = 0;
    cyc = 0;
    while (n < 12 && cyc < 40) begin
      @(negedge clk);
      if (bus_sel && bus_ready) begin
        check("wrap_addr", 32'(bus_addr), 32'h40 + n);
        check("wrap_wdata", 32'(bus_wdata), 32'hB000 + n);
        n++;
      end
      hs = req_valid && req_ready;
      step();
      cyc++;
      if (hs) begin
        nxt++;
        if (nxt < 12) begin
          req_addr = 8'(8'h40 + nxt);
          req_wdata = 16'(16'hB000 + nxt);
        end else req_valid = 1'b0;
      end
    end
    check("wrap_count", n, 12);
    check("wrap_cycles", cyc, 12);
    req_valid = 1'b0;
    step();

    // Reset while a read sits in its wait cycle with a write queued.
    rsp_ready = 1'b1;
    push(1'b0, 8'h10, 16'h0);
    push(1'b1, 8'h50, 16'h5555);
    @(negedge clk);
    check("mid_wait_busy", 32'(busy), 1);
    rstn = 1'b0;
    step();
    @(negedge clk);
    check("mid_rst_rsp", 32'(rsp_valid), 0);
    check("mid_rst_sel", 32'(bus_sel), 0);
    check("mid_rst_ready", 32'(req_ready), 1);
    check("mid_rst_busy", 32'(busy), 0);
    rstn = 1'b1;
    step();
    push(1'b0, 8'h10, 16'h0);
    done = 0;
    for (int t = 0; t < 10 && !done; t++) begin
      @(negedge clk);
      if (rsp_valid) begin
        check("post_rst_addr", 32'(rsp_addr), 32'h10);
        check("post_rst_data", 32'(rsp_rdata), 32'h1234);
        done = 1;
      end
      step();
    end
    if (!done) check("post_rst_timeout", 0, 1);

    // Vector table.
    foreach (vecs[k]) begin
      push(vecs[k].wr, vecs[k].addr, vecs[k].wdata);
      done = 0;
      for (int t = 0; t < 10 && !done; t++) begin
        @(negedge clk);
        if (vecs[k].wr) begin
          if (!busy) done = 1;
        end else if (rsp_valid) begin
          check("vec_addr", 32'(rsp_addr), 32'(vecs[k].addr));
          check("vec_data", 32'(rsp_rdata), 32'(vecs[k].exp));
          done = 1;
        end
        step();
      end
      if (!done) check("vec_timeout", 0, 1);
    end

    // Random traffic against the scoreboard.
    reset_dut();
    for (int i = 0; i < 256; i++) mdl[i] = 16'h1234;
    bus_q.delete();
    exp_q.delete();
    mon_en = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      req_valid = ($urandom % 3) != 0;
      req_wr    = 1'($urandom % 2);
      req_addr  = 8'($urandom % 16);
      req_wdata = 16'($urandom);
      rsp_ready = 1'($urandom % 2);
      stall     = ($urandom % 4) == 0;
      step();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    stall = 1'b0;
    done = 0;
    for (int t = 0; t < 300 && !done; t++) begin
      @(negedge clk);
      if (!busy && !rsp_valid && bus_q.size() == 0 && exp_q.size() == 0)
        done = 1;
      step();
    end
    mon_en = 1'b0;
    check("rnd_drained", 32'(done), 1);
    check("rnd_bus_left", bus_q.size(), 0);
    check("rnd_rsp_left", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
